axi_rd_protocol: RTL and testbench
==================================

AXI_RD_PROTOCOL -- requirements
Module: axi_rd_protocol

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 64, data width.
REQ-002 axi_aclk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 araddr_in/arlen_in/arsize_in/arburst_in  in  AW/8/3/2  read request payload from the master model.
REQ-005 arvalid_in  in  1  request valid from the master model.
REQ-006 rdata_in/rresp_in  in  DW/2  read beat payload from the slave model.
REQ-007 rvalid_in  in  1  slave has a beat; rready_in  in  1  master can accept a beat.
REQ-008 axi_araddr/axi_arlen/axi_arsize/axi_arburst  out  AW/8/3/2  registered AR payload.
REQ-009 axi_arvalid, axi_arready  out  1  registered AR handshake.
REQ-010 axi_rdata/axi_rresp  out  DW/2  registered R payload.
REQ-011 axi_rlast, axi_rvalid, axi_rready  out  1  registered R handshake and last-beat flag.
REQ-012 r_active  out  1  accepted burst in progress; r_beat_addr  out  AW  address of current beat; r_err  out  1  sticky protocol/response error.

Function
REQ-013 AR FSM and R FSM SHALL each use states WAIT=2'b00, COMMIT=2'b01 (valid&ready), ASSERT=2'b10 (valid, not ready); at most one burst outstanding.
REQ-014 AR WAIT: arvalid_in & ~r_active -> capture payload, axi_arvalid=1, axi_arready=1, go COMMIT; arvalid_in & r_active -> capture, axi_arvalid=1, axi_arready=0, go ASSERT; else axi_arvalid=0, axi_arready=~r_active.
REQ-015 AR COMMIT (one cycle): r_active=1, beats_left=axi_arlen, r_beat_addr=axi_araddr, latch size/burst, axi_arvalid=0, axi_arready=0, go WAIT.
REQ-016 AR ASSERT: payload and axi_arvalid held stable; when ~r_active, axi_arready=1, go COMMIT.
REQ-017 R WAIT: r_active & rvalid_in & rready_in -> capture rdata/rresp, axi_rvalid=1, axi_rready=1, axi_rlast=(beats_left==0), go COMMIT; r_active & rvalid_in only -> capture, axi_rvalid=1, axi_rready=0, go ASSERT; else axi_rvalid=0, axi_rready=rready_in.
REQ-018 R ASSERT: payload and axi_rvalid held; on rready_in, axi_rready=1, axi_rlast=(beats_left==0), go COMMIT.
REQ-019 R COMMIT: beat counted; if axi_rlast: r_active=0, axi_rvalid/axi_rready/axi_rlast=0, go WAIT; else beats_left-=1, advance r_beat_addr, then apply REQ-017 decision for next beat (back-to-back, one beat per cycle).
REQ-020 Beat address: FIXED (00) unchanged; INCR (01) += 1<<arsize, modulo 2^AW; reserved (11) treated as INCR and sets r_err.
REQ-021 rvalid_in while ~r_active SHALL be ignored (no state change) and SHALL set r_err.
REQ-022 Committed beat with rresp_in != 2'b00 SHALL set r_err; axi_rresp carries the value.
REQ-023 Simultaneous final-beat COMMIT and pending AR ASSERT: r_active clears first; AR accept occurs the following cycle, never overlapping.
REQ-024 arlen=0 SHALL produce exactly one beat with axi_rlast=1.

Reset
REQ-025 On rst: AR/R FSMs in WAIT, axi_arready=1, all other outputs, r_active, r_err, beats_left, r_beat_addr = 0.
REQ-026 Reset mid-burst SHALL abandon the burst; no residual beat or rlast after rst deasserts.

Configuration
REQ-027 Macro AXI_RD_WRAP_EN defined: WRAP (10) beats wrap within boundary (arlen+1)<<arsize aligned down from araddr; arlen not in {1,3,7,15} sets r_err and falls back to INCR.
REQ-028 AXI_RD_WRAP_EN undefined: WRAP treated as INCR with no r_err; no wrap logic compiled.

Verification
REQ-029 araddr=0x1000, arlen=3, size=3, INCR, rvalid_in/rready_in held high -> 4 consecutive beats, r_beat_addr 0x1000/08/10/18, axi_rlast only on beat 4, r_active clears after.
REQ-030 Second arvalid_in during active burst -> AR in ASSERT, axi_arready=0 until last beat commits, accepted next cycle.
REQ-031 rready_in low 3 cycles mid-burst -> R in ASSERT, axi_rdata stable, no beat counted until rready_in rises.
REQ-032 rvalid_in=1 with no request -> no beat, r_err=1 and stays 1 until rst.
REQ-033 AXI_RD_WRAP_EN: araddr=0x1008, arlen=3, size=3, WRAP -> addresses 0x1008/10/18/00; without macro -> 0x1008/10/18/20.
REQ-034 rst asserted after beat 2 of arlen=7 -> next cycle all outputs at reset values, axi_arready=1, no further beats.

Source files
------------

// File: rtl/axi_rd_protocol.sv
// AXI read-channel protocol block: registered AR/R handshakes, single outstanding burst,
// beat address generation and sticky error flag. Define AXI_RD_WRAP_EN to build WRAP bursts.
module axi_rd_protocol #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          axi_aclk,
  input  logic          rst,
  input  logic [AW-1:0] araddr_in,
  input  logic [7:0]    arlen_in,
  input  logic [2:0]    arsize_in,
  input  logic [1:0]    arburst_in,
  input  logic          arvalid_in,
  input  logic [DW-1:0] rdata_in,
  input  logic [1:0]    rresp_in,
  input  logic          rvalid_in,
  input  logic          rready_in,
  output logic [AW-1:0] axi_araddr,
  output logic [7:0]    axi_arlen,
  output logic [2:0]    axi_arsize,
  output logic [1:0]    axi_arburst,
  output logic          axi_arvalid,
  output logic          axi_arready,
  output logic [DW-1:0] axi_rdata,
  output logic [1:0]    axi_rresp,
  output logic          axi_rlast,
  output logic          axi_rvalid,
  output logic          axi_rready,
  output logic          r_active,
  output logic [AW-1:0] r_beat_addr,
  output logic          r_err
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_COMMIT = 2'b01,
    ST_ASSERT = 2'b10
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  state_t ar_state, ar_next, r_state, r_next;

  logic [7:0]    beats_left, beats_left_d;
  logic [2:0]    cur_size, cur_size_d;
  logic [1:0]    cur_burst, cur_burst_d;
  logic [AW-1:0] wrap_mask, wrap_mask_d;

  logic [AW-1:0] araddr_d, beat_addr_d;
  logic [7:0]    arlen_d;
  logic [2:0]    arsize_d;
  logic [1:0]    arburst_d, rresp_d;
  logic [DW-1:0] rdata_d;
  logic          arvalid_d, arready_d, rlast_d, rvalid_d, rready_d, active_d, err_d;
  logic          r_take, last_if_taken;

  logic [AW-1:0] beat_step, beat_incr, beat_next;

  always_comb begin
    beat_step = AW'(1) << cur_size;
    beat_incr = r_beat_addr + beat_step;
    beat_next = beat_incr;
    if (cur_burst == BURST_FIXED) begin
      beat_next = r_beat_addr;
    end
`ifdef AXI_RD_WRAP_EN
    else if (cur_burst == BURST_WRAP) begin
      beat_next = (r_beat_addr & ~wrap_mask) | (beat_incr & wrap_mask);
    end
`endif
  end

  always_comb begin
    ar_next       = ar_state;
    r_next        = r_state;
    araddr_d      = axi_araddr;
    arlen_d       = axi_arlen;
    arsize_d      = axi_arsize;
    arburst_d     = axi_arburst;
    arvalid_d     = axi_arvalid;
    arready_d     = axi_arready;
    rdata_d       = axi_rdata;
    rresp_d       = axi_rresp;
    rlast_d       = axi_rlast;
    rvalid_d      = axi_rvalid;
    rready_d      = axi_rready;
    active_d      = r_active;
    err_d         = r_err;
    beat_addr_d   = r_beat_addr;
    beats_left_d  = beats_left;
    cur_size_d    = cur_size;
    cur_burst_d   = cur_burst;
    wrap_mask_d   = wrap_mask;
    r_take        = 1'b0;
    last_if_taken = (beats_left == 8'd0);

    case (ar_state)
      ST_WAIT: begin
        if (arvalid_in) begin
          araddr_d  = araddr_in;
          arlen_d   = arlen_in;
          arsize_d  = arsize_in;
          arburst_d = arburst_in;
          arvalid_d = 1'b1;
          arready_d = ~r_active;
          ar_next   = r_active ? ST_ASSERT : ST_COMMIT;
        end else begin
          arvalid_d = 1'b0;
          arready_d = ~r_active;
        end
      end
      ST_COMMIT: begin
        active_d     = 1'b1;
        beats_left_d = axi_arlen;
        beat_addr_d  = axi_araddr;
        cur_size_d   = axi_arsize;
        arvalid_d    = 1'b0;
        arready_d    = 1'b0;
        ar_next      = ST_WAIT;
        case (axi_arburst)
          BURST_FIXED: cur_burst_d = BURST_FIXED;
          BURST_INCR:  cur_burst_d = BURST_INCR;
          BURST_WRAP: begin
`ifdef AXI_RD_WRAP_EN
            if (axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) begin
              cur_burst_d = BURST_WRAP;
              wrap_mask_d = ((AW'(axi_arlen) + AW'(1)) << axi_arsize) - AW'(1);
            end else begin
              cur_burst_d = BURST_INCR;
              err_d       = 1'b1;
            end
`else
            cur_burst_d = BURST_INCR;
`endif
          end
          default: begin
            cur_burst_d = BURST_INCR;
            err_d       = 1'b1;
          end
        endcase
      end
      ST_ASSERT: begin
        if (!r_active) begin
          arready_d = 1'b1;
          ar_next   = ST_COMMIT;
        end
      end
      default: ar_next = ST_WAIT;
    endcase

    // AR COMMIT only runs while r_active is low and R COMMIT only while it is high,
    // so the shared burst registers are never written by both FSMs in one cycle.
    case (r_state)
      ST_WAIT: begin
        r_take = 1'b1;
        if (rvalid_in && !r_active) begin
          err_d = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (rready_in) begin
          rready_d = 1'b1;
          rlast_d  = (beats_left == 8'd0);
          r_next   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (axi_rresp != 2'b00) begin
          err_d = 1'b1;
        end
        if (axi_rlast) begin
          active_d = 1'b0;
          rvalid_d = 1'b0;
          rready_d = 1'b0;
          rlast_d  = 1'b0;
          r_next   = ST_WAIT;
        end else begin
          beats_left_d  = beats_left - 8'd1;
          beat_addr_d   = beat_next;
          r_take        = 1'b1;
          last_if_taken = (beats_left == 8'd1);
        end
      end
      default: r_next = ST_WAIT;
    endcase

    if (r_take) begin
      if (r_active && rvalid_in) begin
        rdata_d  = rdata_in;
        rresp_d  = rresp_in;
        rvalid_d = 1'b1;
        rready_d = rready_in;
        rlast_d  = rready_in & last_if_taken;
        r_next   = rready_in ? ST_COMMIT : ST_ASSERT;
      end else begin
        rvalid_d = 1'b0;
        rready_d = rready_in;
        rlast_d  = 1'b0;
        r_next   = ST_WAIT;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      ar_state    <= ST_WAIT;
      r_state     <= ST_WAIT;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      axi_arsize  <= '0;
      axi_arburst <= '0;
      axi_arvalid <= 1'b0;
      axi_arready <= 1'b1;
      axi_rdata   <= '0;
      axi_rresp   <= '0;
      axi_rlast   <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rready  <= 1'b0;
      r_active    <= 1'b0;
      r_beat_addr <= '0;
      r_err       <= 1'b0;
      beats_left  <= '0;
      cur_size    <= '0;
      cur_burst   <= '0;
      wrap_mask   <= '0;
    end else begin
      ar_state    <= ar_next;
      r_state     <= r_next;
      axi_araddr  <= araddr_d;
      axi_arlen   <= arlen_d;
      axi_arsize  <= arsize_d;
      axi_arburst <= arburst_d;
      axi_arvalid <= arvalid_d;
      axi_arready <= arready_d;
      axi_rdata   <= rdata_d;
      axi_rresp   <= rresp_d;
      axi_rlast   <= rlast_d;
      axi_rvalid  <= rvalid_d;
      axi_rready  <= rready_d;
      r_active    <= active_d;
      r_beat_addr <= beat_addr_d;
      r_err       <= err_d;
      beats_left  <= beats_left_d;
      cur_size    <= cur_size_d;
      cur_burst   <= cur_burst_d;
      wrap_mask   <= wrap_mask_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_protocol.sv
// Directed bench for axi_rd_protocol: a per-burst expected-beat table checked on every
// committed beat, plus literal checks of handshake timing, reset and error behaviour.
module tb_axi_rd_protocol;

  logic        axi_aclk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr_in = '0;
  logic [7:0]  arlen_in = '0;
  logic [2:0]  arsize_in = '0;
  logic [1:0]  arburst_in = '0;
  logic        arvalid_in = 1'b0;
  logic [63:0] rdata_in = '0;
  logic [1:0]  rresp_in = '0;
  logic        rvalid_in = 1'b0;
  logic        rready_in = 1'b0;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid, axi_arready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;
  logic        r_active;
  logic [31:0] r_beat_addr;
  logic        r_err;

  axi_rd_protocol #(.AW(32), .DW(64)) dut (
    .axi_aclk(axi_aclk), .rst(rst),
    .araddr_in(araddr_in), .arlen_in(arlen_in), .arsize_in(arsize_in),
    .arburst_in(arburst_in), .arvalid_in(arvalid_in),
    .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in), .rready_in(rready_in),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .r_active(r_active), .r_beat_addr(r_beat_addr), .r_err(r_err)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expected beats, in order of commitment
  logic [31:0] exp_addr [0:63];
  logic [63:0] exp_data [0:63];
  logic [1:0]  exp_resp [0:63];
  logic        exp_last [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // beats actually committed in the current scenario
  logic [31:0] seen_addr [0:63];
  logic        seen_last [0:63];
  int          seen_cyc  [0:63];
  int nseen = 0;

  // slave model state
  logic [31:0] s_tag = '0;
  int s_idx = 0;
  int s_bad = 255;
  logic pv = 1'b0;
  logic pr = 1'b0;

  function automatic logic [63:0] data_of(input logic [31:0] tag, input int idx);
    return {tag, 32'hC0DE_0000 | 32'(idx)};
  endfunction

  // address of beat i from the burst rules directly, not by stepping
  function automatic logic [31:0] model_addr(input logic [31:0] addr, input int len,
                                             input int size, input logic [1:0] burst, input int i);
    if (burst == 2'b00) return addr;
`ifdef AXI_RD_WRAP_EN
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15))
      return (addr & ~((32'(len + 1) << size) - 32'd1)) |
             ((addr + (32'(i) << size)) & ((32'(len + 1) << size) - 32'd1));
`endif
    return addr + (32'(i) << size);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_burst(input logic [31:0] addr, input int len, input int size,
                            input logic [1:0] burst, input logic [31:0] tag, input int bad);
    for (int i = 0; i <= len; i++) begin
      exp_addr[wr_ptr] = model_addr(addr, len, size, burst, i);
      exp_data[wr_ptr] = data_of(tag, i);
      exp_resp[wr_ptr] = (i == bad) ? 2'b10 : 2'b00;
      exp_last[wr_ptr] = (i == len);
      wr_ptr++;
    end
  endtask

  task automatic compare_cycle();
    chk("rvalid_without_active", 64'(axi_rvalid & ~r_active), 64'd0);
    if (axi_rvalid && axi_rready) begin
      if (rd_ptr == wr_ptr) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: beat at addr %h, expected no beat (cycle %0d)", r_beat_addr, cyc);
      end else begin
        chk("beat_addr", 64'(r_beat_addr), 64'(exp_addr[rd_ptr]));
        chk("beat_data", axi_rdata, exp_data[rd_ptr]);
        chk("beat_resp", 64'(axi_rresp), 64'(exp_resp[rd_ptr]));
        chk("beat_last", 64'(axi_rlast), 64'(exp_last[rd_ptr]));
        rd_ptr++;
      end
      if (nseen < 64) begin
        seen_addr[nseen] = r_beat_addr;
        seen_last[nseen] = axi_rlast;
        seen_cyc[nseen]  = cyc;
        nseen++;
      end
    end
  endtask

  task automatic cycle();
    logic stall;
    @(negedge axi_aclk);
    cyc++;
    compare_cycle();
    // a new beat was captured at this edge if the output beat is fresh
    if (axi_rvalid && (!pv || pr)) s_idx++;
    stall = axi_rvalid && !axi_rready;
    pv = axi_rvalid;
    pr = axi_rready;
    rdata_in = stall ? ~data_of(s_tag, s_idx) : data_of(s_tag, s_idx);
    rresp_in = stall ? 2'b11 : ((s_idx == s_bad) ? 2'b10 : 2'b00);
  endtask

  task automatic slave_start(input logic [31:0] tag, input int bad);
    s_tag = tag;
    s_idx = 0;
    s_bad = bad;
    rdata_in = data_of(tag, 0);
    rresp_in = (bad == 0) ? 2'b10 : 2'b00;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    araddr_in = addr; arlen_in = len; arsize_in = size; arburst_in = burst;
    arvalid_in = 1'b1;
    cycle();
    arvalid_in = 1'b0;
  endtask

  task automatic wait_active();
    int n = 0;
    while (!r_active && n < 20) begin cycle(); n++; end
    if (!r_active) begin
      checks++; errors++;
      $display("FAIL wait_active: r_active still 0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_last();
    int n = 0;
    bit done = 0;
    while (!done && n < 60) begin
      cycle(); n++;
      done = axi_rvalid && axi_rready && axi_rlast;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_last: no last beat within %0d cycles, expected one", n);
    end
  endtask

  task automatic wait_seen(input int target);
    int n = 0;
    while (nseen < target && n < 40) begin cycle(); n++; end
    if (nseen < target) begin
      checks++; errors++;
      $display("FAIL wait_seen: %0d beats seen, expected %0d", nseen, target);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_araddr"},  64'(axi_araddr), 64'd0);
    chk({tag, "_arlen"},   64'(axi_arlen), 64'd0);
    chk({tag, "_arsize"},  64'(axi_arsize), 64'd0);
    chk({tag, "_arburst"}, 64'(axi_arburst), 64'd0);
    chk({tag, "_arvalid"}, 64'(axi_arvalid), 64'd0);
    chk({tag, "_arready"}, 64'(axi_arready), 64'd1);
    chk({tag, "_rdata"},   axi_rdata, 64'd0);
    chk({tag, "_rresp"},   64'(axi_rresp), 64'd0);
    chk({tag, "_rlast"},   64'(axi_rlast), 64'd0);
    chk({tag, "_rvalid"},  64'(axi_rvalid), 64'd0);
    chk({tag, "_rready"},  64'(axi_rready), 64'd0);
    chk({tag, "_r_active"}, 64'(r_active), 64'd0);
    chk({tag, "_beat_addr"}, 64'(r_beat_addr), 64'd0);
    chk({tag, "_r_err"},   64'(r_err), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rvalid_in = 1'b0; rready_in = 1'b0; arvalid_in = 1'b0;
    cycle();
    cycle();
    check_reset_values("reset");
    rst = 1'b0;
    nseen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // INCR 0x1000 len3 size3, handshakes held high
    push_burst(32'h1000, 3, 3, 2'b01, 32'h1, 255);
    issue(32'h1000, 8'd3, 3'd3, 2'b01);
    wait_active();
    slave_start(32'h1, 255);
    rvalid_in = 1'b1; rready_in = 1'b1;
    wait_last();
    rvalid_in = 1'b0;
    cycle();
    chk("incr_active_cleared", 64'(r_active), 64'd0);
    chk("incr_nbeats", 64'(nseen), 64'd4);
    chk("incr_addr0", 64'(seen_addr[0]), 64'h1000);
    chk("incr_addr1", 64'(seen_addr[1]), 64'h1008);
    chk("incr_addr2", 64'(seen_addr[2]), 64'h1010);
    chk("incr_addr3", 64'(seen_addr[3]), 64'h1018);
    chk("incr_last_pattern", 64'({seen_last[0], seen_last[1], seen_last[2], seen_last[3]}), 64'b0001);
    chk("incr_back_to_back", 64'(seen_cyc[3] - seen_cyc[0]), 64'd3);
    chk("incr_no_err", 64'(r_err), 64'd0);

    // second request while a burst is active
    nseen = 0;
    push_burst(32'h3000, 1, 3, 2'b01, 32'h3, 255);
    push_burst(32'h4000, 0, 2, 2'b00, 32'h4, 255);
    issue(32'h3000, 8'd1, 3'd3, 2'b01);
    wait_active();
    issue(32'h4000, 8'd0, 3'd2, 2'b00);
    chk("ar2_held_valid", 64'(axi_arvalid), 64'd1);
    chk("ar2_not_ready", 64'(axi_arready), 64'd0);
    chk("ar2_payload", 64'(axi_araddr), 64'h4000);
    slave_start(32'h3, 255);
    rvalid_in = 1'b1; rready_in = 1'b1;
    wait_last();
    chk("ar2_ready_on_last", 64'(axi_arready), 64'd0);
    rvalid_in = 1'b0;
    cycle();
    chk("ar2_active_off", 64'(r_active), 64'd0);
    chk("ar2_no_overlap", 64'(axi_arready), 64'd0);
    cycle();
    chk("ar2_accept_ready", 64'(axi_arready), 64'd1);
    chk("ar2_accept_valid", 64'(axi_arvalid), 64'd1);
    cycle();
    chk("ar2_active_on", 64'(r_active), 64'd1);
    chk("ar2_valid_dropped", 64'(axi_arvalid), 64'd0);
    chk("ar2_start_addr", 64'(r_beat_addr), 64'h4000);
    slave_start(32'h4, 255);
    rvalid_in = 1'b1;
    wait_last();
    rvalid_in = 1'b0;
    cycle();
    chk("ar2_nbeats", 64'(nseen), 64'd3);
    chk("ar2_fixed_last_single", 64'(seen_last[2]), 64'd1);

    // WRAP request
    nseen = 0;
    push_burst(32'h1008, 3, 3, 2'b10, 32'h7, 255);
    issue(32'h1008, 8'd3, 3'd3, 2'b10);
    wait_active();
    slave_start(32'h7, 255);
    rvalid_in = 1'b1;
    wait_last();
    rvalid_in = 1'b0;
    cycle();
    chk("wrap_addr1", 64'(seen_addr[1]), 64'h1010);
    chk("wrap_addr2", 64'(seen_addr[2]), 64'h1018);
`ifdef AXI_RD_WRAP_EN
    chk("wrap_addr3", 64'(seen_addr[3]), 64'h1000);
`else
    chk("wrap_addr3", 64'(seen_addr[3]), 64'h1020);
`endif
    chk("wrap_no_err", 64'(r_err), 64'd0);

    // rready stall mid-burst, error response on beat 2
    nseen = 0;
    push_burst(32'h2000, 3, 2, 2'b01, 32'h2, 2);
    issue(32'h2000, 8'd3, 3'd2, 2'b01);
    wait_active();
    slave_start(32'h2, 2);
    rvalid_in = 1'b1;
    wait_seen(1);
    rready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rvalid", 64'(axi_rvalid), 64'd1);
      chk("stall_rready", 64'(axi_rready), 64'd0);
      chk("stall_rdata", axi_rdata, data_of(32'h2, 1));
    end
    chk("stall_no_beat", 64'(nseen), 64'd1);
    rready_in = 1'b1;
    wait_last();
    rvalid_in = 1'b0;
    cycle();
    chk("stall_nbeats", 64'(nseen), 64'd4);
    chk("resp_err_set", 64'(r_err), 64'd1);
    do_reset();

    // rvalid with no request outstanding
    rvalid_in = 1'b1; rready_in = 1'b1;
    cycle();
    cycle();
    rvalid_in = 1'b0;
    chk("orphan_err", 64'(r_err), 64'd1);
    chk("orphan_inactive", 64'(r_active), 64'd0);
    for (int i = 0; i < 3; i++) cycle();
    chk("orphan_err_sticky", 64'(r_err), 64'd1);
    do_reset();

    // reserved burst code behaves as INCR and flags an error
    push_burst(32'h55, 1, 0, 2'b11, 32'h6, 255);
    issue(32'h55, 8'd1, 3'd0, 2'b11);
    wait_active();
    slave_start(32'h6, 255);
    rvalid_in = 1'b1; rready_in = 1'b1;
    wait_last();
    rvalid_in = 1'b0;
    cycle();
    chk("reserved_addr1", 64'(seen_addr[1]), 64'h56);
    chk("reserved_err", 64'(r_err), 64'd1);
    do_reset();

    // reset in the middle of an 8-beat burst
    push_burst(32'h5000, 7, 3, 2'b01, 32'h5, 255);
    issue(32'h5000, 8'd7, 3'd3, 2'b01);
    wait_active();
    slave_start(32'h5, 255);
    rvalid_in = 1'b1; rready_in = 1'b1;
    wait_seen(2);
    rst = 1'b1; rvalid_in = 1'b0; rready_in = 1'b0;
    wr_ptr = rd_ptr;
    cycle();
    check_reset_values("midreset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("post_reset_rvalid", 64'(axi_rvalid), 64'd0);
      chk("post_reset_rlast", 64'(axi_rlast), 64'd0);
      chk("post_reset_active", 64'(r_active), 64'd0);
    end
    chk("pending_beats", 64'(wr_ptr - rd_ptr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
